// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. Two-flop input synchroniser, mid-bit sampling
// driven by a baud counter, framing check on the stop bit, and registered
// one-cycle strobes for a good byte or a framing error.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | line idle, waiting for rx_s low
// S_START  | inside start bit, confirm it is still low at mid-bit
// S_DATA   | sampling 8 data bits, LSB first, one per bit period
// S_STOP   | waiting for mid-point of stop bit, check it is high
// S_BREAK  | stop bit was low; wait for the line to go high again

module uart_rx #(
    parameter int KBAUD    = 10416,
    parameter int CNT_BITS = $clog2(KBAUD + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    output logic [7:0] Rx_data,
    output logic       Rx_done,
    output logic       Rx_busy,
    output logic       Frame_err
);

    localparam logic [CNT_BITS-1:0] LAST    = CNT_BITS'(KBAUD);
    localparam logic [CNT_BITS-1:0] HALF_M1 = CNT_BITS'((KBAUD + 1) / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic                sync1_q, sync2_q;
    logic                rx_s;
    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [2:0]          idx_q, idx_d;
    logic [7:0]          shift_q, shift_d;
    logic                ok_d, bad_d;
    logic                ok_q, bad_q;
    logic [7:0]          data_q;
    logic                done_q, err_q;

    assign rx_s = sync2_q;

    // Two-flop synchroniser for the asynchronous RX pin, resets to idle-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= RX;
            sync2_q <= sync1_q;
        end
    end

    // FSM state, baud counter, bit index and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic; the counter restarts on every state change and at
    // each data-bit boundary.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: stop-bit verdict at its mid-point, busy outside IDLE.
    always_comb begin
        ok_d    = (state_q == S_STOP) && (cnt_q == LAST) &&  rx_s;
        bad_d   = (state_q == S_STOP) && (cnt_q == LAST) && !rx_s;
        Rx_busy = (state_q != S_IDLE);
    end

    // Output register: verdict is captured first, then the byte and strobes
    // are presented together one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ok_q   <= 1'b0;
            bad_q  <= 1'b0;
            data_q <= 8'h00;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            ok_q   <= ok_d;
            bad_q  <= bad_d;
            done_q <= ok_q;
            err_q  <= bad_q;
            if (ok_q) data_q <= shift_q;
        end
    end

    assign Rx_data   = data_q;
    assign Rx_done   = done_q;
    assign Frame_err = err_q;

endmodule
